cpu_bus_target: RTL

//  Bus responder for the 6502 core: services every CPU bus cycle (aout/dout/mr/mw) and

---
 rtl/cpu_bus_pkg.sv | 19 +
 rtl/cpu_bus_target_if.sv | 19 +
 rtl/cpu_bus_ram.sv | 25 ++
 rtl/cpu_bus_target.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the 6502 bus responder.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRamDone,
    StExtWait,
    StDone
  } bus_state_e;

  // Read data returned to the CPU when an external access times out.
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

  // True when every address bit above the RAM window is zero.
  function automatic logic is_internal(input logic [15:0] addr, input int unsigned aw);
    return (addr >> aw) == 16'd0;
  endfunction

endpackage

// File: rtl/cpu_bus_target_if.sv
// CPU-side bus of the 6502 core: address/data/strobes out, clock enable and read data back.
interface cpu_bus_target_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_mw;
  logic        cpu_mr;
  logic        cpu_ce;
  logic [7:0]  cpu_din;

  modport master (
    output cpu_addr, cpu_dout, cpu_mw, cpu_mr,
    input  cpu_ce, cpu_din
  );

  modport slave (
    input  cpu_addr, cpu_dout, cpu_mw, cpu_mr,
    output cpu_ce, cpu_din
  );
endinterface

// File: rtl/cpu_bus_ram.sv
// Single-port synchronous RAM, read-first, one clock read latency; maps onto block RAM.
module cpu_bus_ram #(
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    q
);

  logic [7:0] mem [2**AW];

  // Read-first: q shows the old contents even on a write cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/cpu_bus_target.sv
// Bus responder for the 6502 core: decodes each CPU bus cycle to on-chip RAM or an external
// req/ack port and paces the core through cpu_ce.
// Optional feature: define CPU_BUS_TIMEOUT_EN to enable the external-access timeout,
// the 8'hFF timeout return and the sticky bus_err flag.
module cpu_bus_target
  import cpu_bus_pkg::*;
#(
  parameter int unsigned RAM_AW      = 11,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  cpu_bus_target_if.slave  bus,
  output logic             ext_req,
  output logic             ext_we,
  output logic [15:0]      ext_addr,
  output logic [7:0]       ext_wdata,
  input  logic [7:0]       ext_rdata,
  input  logic             ext_ack,
  output logic             bus_err,
  input  logic             err_clr
);

  bus_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  data_q, data_d;
  logic        ext_req_q, ext_req_d;
  logic        ram_en, ram_we;
  logic [7:0]  ram_q;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_hit;
  logic       bus_err_q, bus_err_d;
`endif

  cpu_bus_ram #(
    .AW (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (bus.cpu_addr[RAM_AW-1:0]),
    .wdata (bus.cpu_dout),
    .q     (ram_q)
  );

  // Next-state: start accesses in idle, wait for ack (or timeout) on the external port.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    data_d    = data_q;
    ext_req_d = ext_req_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
`ifdef CPU_BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (run) begin
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_dout;
          we_d    = bus.cpu_mw;
          data_d  = 8'h00;
          if (is_internal(bus.cpu_addr, RAM_AW)) begin
            ram_en  = 1'b1;
            ram_we  = bus.cpu_mw;
            state_d = StRamDone;
          end else begin
            ext_req_d = 1'b1;
            state_d   = StExtWait;
          end
        end
      end
      StRamDone: state_d = StIdle;
      StExtWait: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (ext_ack) begin
          data_d    = we_q ? 8'h00 : ext_rdata;
          ext_req_d = 1'b0;
          state_d   = StDone;
        end
`ifdef CPU_BUS_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          data_d      = we_q ? 8'h00 : TIMEOUT_DATA;
          ext_req_d   = 1'b0;
          timeout_hit = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
`ifdef CPU_BUS_TIMEOUT_EN
        cnt_d = 8'd0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched-request registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      data_q    <= 8'h00;
      ext_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      data_q    <= data_d;
      ext_req_q <= ext_req_d;
    end
  end

`ifdef CPU_BUS_TIMEOUT_EN
  // Sticky error: a new timeout beats a simultaneous clear.
  always_comb begin
    bus_err_d = bus_err_q;
    if (timeout_hit) begin
      bus_err_d = 1'b1;
    end else if (err_clr) begin
      bus_err_d = 1'b0;
    end
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic       unused_err_clr;
  logic [7:0] unused_timeout_cyc;
  assign unused_err_clr     = err_clr;
  assign unused_timeout_cyc = 8'(TIMEOUT_CYC);
  assign bus_err            = 1'b0;
`endif

  // Direction comes from cpu_mw alone.
  logic unused_cpu_mr;
  assign unused_cpu_mr = bus.cpu_mr;

  // CPU-facing outputs: enable only in completion states, data forced to 0 otherwise.
  always_comb begin
    bus.cpu_ce  = 1'b0;
    bus.cpu_din = 8'h00;
    unique case (state_q)
      StRamDone: begin
        bus.cpu_ce  = 1'b1;
        bus.cpu_din = we_q ? 8'h00 : ram_q;
      end
      StDone: begin
        bus.cpu_ce  = 1'b1;
        bus.cpu_din = data_q;
      end
      default: ;
    endcase
  end

  assign ext_req   = ext_req_q;
  assign ext_we    = we_q;
  assign ext_addr  = addr_q;
  assign ext_wdata = wdata_q;

endmodule
